// File: rtl/vga_timing_pkg.sv
// Shared raster timing defaults and helpers for the VGA timing generator.
package vga_timing_pkg;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam int unsigned DEF_SYNC_DELAY = 2;

  localparam int unsigned COORD_LIMIT = 1024;

  typedef logic [9:0] coord_t;

  function automatic int unsigned h_total(input int unsigned vis, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return vis + front + sync + back;
  endfunction

  function automatic int unsigned v_total(input int unsigned vis, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return vis + front + sync + back;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Resettable multi-bit shift pipeline; DEPTH=0 degenerates to a wire.
module sync_delay_line #(
  parameter int unsigned         WIDTH     = 1,
  parameter int unsigned         DEPTH     = 2,
  parameter logic [WIDTH-1:0]    RESET_VAL = '1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic w_unused;
      assign w_unused = i_clk ^ i_rst_n;
      assign o_q = i_d;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [DEPTH];

      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
        end else begin
          r_stage[0] <= i_d;
          for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_q = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters with zero-latency blank decode, delayed hs/vs and a
// once-per-frame vblank strobe plus frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT    = DEF_H_FRONT,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BACK     = DEF_H_BACK,
  parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT    = DEF_V_FRONT,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BACK     = DEF_V_BACK,
  parameter int unsigned SYNC_DELAY = DEF_SYNC_DELAY
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        vblank_start,
  output logic [15:0] frame_count
);

  localparam int unsigned H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  generate
    if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT || SYNC_DELAY > 4) begin : g_bad_params
      $error("vga_timing_gen: totals must be <= 1024 and SYNC_DELAY within 0..4");
    end
  endgenerate

  // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly
  localparam logic [10:0] HVIS_B = 11'(H_VISIBLE);
  localparam logic [10:0] VVIS_B = 11'(V_VISIBLE);
  localparam logic [10:0] HS_LO  = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_HI  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_LO  = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_HI  = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam coord_t      HC_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t      VC_LAST = coord_t'(V_TOTAL - 1);
  localparam coord_t      VC_VBL  = coord_t'(V_VISIBLE);

  coord_t      r_hc;
  coord_t      r_vc;
  logic        r_vblank_start;
  logic [15:0] r_frame_count;

  logic        w_h_last;
  logic        w_v_last;
  logic        w_vbs_hit;
  logic        w_hs_raw;
  logic        w_vs_raw;
  logic [1:0]  w_sync_dly;

  assign w_h_last  = (r_hc == HC_LAST);
  assign w_v_last  = (r_vc == VC_LAST);
  assign w_vbs_hit = (r_hc == '0) && (r_vc == VC_VBL);

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_hc           <= '0;
      r_vc           <= '0;
      r_vblank_start <= 1'b0;
      r_frame_count  <= '0;
    end else begin
      r_vblank_start <= w_vbs_hit;
      if (w_vbs_hit) r_frame_count <= r_frame_count + 16'd1;
      if (w_h_last) begin
        r_hc <= '0;
        r_vc <= w_v_last ? '0 : r_vc + coord_t'(1);
      end else begin
        r_hc <= r_hc + coord_t'(1);
      end
    end
  end

  assign w_hs_raw = !(({1'b0, r_hc} >= HS_LO) && ({1'b0, r_hc} < HS_HI));
  assign w_vs_raw = !(({1'b0, r_vc} >= VS_LO) && ({1'b0, r_vc} < VS_HI));

  sync_delay_line #(
    .WIDTH     (2),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL (2'b11)
  ) u_sync_delay (
    .i_clk   (vga_clk),
    .i_rst_n (reset_n),
    .i_d     ({w_hs_raw, w_vs_raw}),
    .o_q     (w_sync_dly)
  );

  assign DrawX        = r_hc;
  assign DrawY        = r_vc;
  assign blank        = ({1'b0, r_hc} < HVIS_B) && ({1'b0, r_vc} < VVIS_B) && reset_n;
  assign hs           = w_sync_dly[1];
  assign vs           = w_sync_dly[0];
  assign vblank_start = r_vblank_start;
  assign frame_count  = r_frame_count;

endmodule
